// File: rtl/distance_text_buffer.sv
// Converts distance samples (cm) to decimal ASCII with a double-dabble engine and serves a 4x16 text screen.
// Optional NO SIGNAL timeout banner is enabled by defining DIST_TIMEOUT_EN.
module distance_text_buffer #(
   parameter int unsigned MAX_CM         = 400,
   parameter int unsigned TIMEOUT_CYCLES = 65_000_000
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [15:0] distance_cm,
   input  logic        distance_valid,
   input  logic [6:0]  char_xy,
   output logic [6:0]  char_code,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   localparam logic [16:0]  MAX_W  = 17'(MAX_CM);
   localparam logic [127:0] ROW0   = "DIST:       cm  ";
   localparam logic [127:0] ROW_OK = "STATUS: OK      ";
   localparam logic [127:0] ROW_OR = "OUT OF RANGE    ";
   localparam logic [127:0] ROW_NS = "NO SIGNAL       ";

   state_t      state_q;
   logic [35:0] sh_q;
   logic [35:0] adj_d;
   logic [35:0] sh_d;
   logic [4:0]  cnt_q;
   logic        oor_q;
   logic [15:0] pend_q;
   logic        pend_v_q;
   logic [15:0] src_d;
   logic [19:0] disp_q;
   logic        disp_oor_q;
   logic        busy_q;
   logic [6:0]  char_q;
   logic [6:0]  char_d;
   logic        no_sig;
   logic [1:0]  row;
   logic [3:0]  col;
   logic [3:0]  k;
   logic [3:0]  dig;
   logic [4:0]  blank;
   logic        unused_xy;

   function automatic logic over_max(input logic [15:0] v);
      return {1'b0, v} > MAX_W;
   endfunction

   function automatic logic [6:0] str_at(input logic [127:0] s,
                                         input logic [3:0] c);
      return s[{~c, 3'b000} +: 7];
   endfunction

   always_comb begin
      adj_d = sh_q;
      for (int i = 0; i < 5; i++) begin
         if (sh_q[16+4*i +: 4] >= 4'd5)
            adj_d[16+4*i +: 4] = sh_q[16+4*i +: 4] + 4'd3;
      end
      sh_d  = {adj_d[34:0], 1'b0};
      // a fresh sample beats the pending one when starting from IDLE
      src_d = (state_q == IDLE && distance_valid) ? distance_cm : pend_q;
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sh_q       <= '0;
         cnt_q      <= '0;
         oor_q      <= 1'b0;
         pend_q     <= '0;
         pend_v_q   <= 1'b0;
         disp_q     <= '0;
         disp_oor_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (distance_valid || pend_v_q) begin
                  sh_q     <= {20'd0, src_d};
                  cnt_q    <= '0;
                  oor_q    <= over_max(src_d);
                  pend_v_q <= 1'b0;
                  state_q  <= SHIFT;
                  busy_q   <= 1'b1;
               end
            end
            SHIFT: begin
               sh_q  <= sh_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd15)
                  state_q <= COMMIT;
               if (distance_valid) begin
                  pend_q   <= distance_cm;
                  pend_v_q <= 1'b1;
               end
            end
            COMMIT: begin
               disp_q     <= sh_q[35:16];
               disp_oor_q <= oor_q;
               if (pend_v_q) begin
                  sh_q    <= {20'd0, src_d};
                  cnt_q   <= '0;
                  oor_q   <= over_max(src_d);
                  state_q <= SHIFT;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               pend_v_q <= distance_valid;
               if (distance_valid)
                  pend_q <= distance_cm;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef DIST_TIMEOUT_EN
   localparam logic [25:0] TO_W = 26'(TIMEOUT_CYCLES);
   logic [25:0] to_q;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst)
         to_q <= '0;
      else if (distance_valid)
         to_q <= '0;
      else if (to_q != TO_W)
         to_q <= to_q + 26'd1;
   end

   assign no_sig = (to_q == TO_W);
`else
   assign no_sig = 1'b0;
`endif

   assign row       = char_xy[5:4];
   assign col       = char_xy[3:0];
   assign unused_xy = char_xy[6];

   always_comb begin
      blank    = '0;
      blank[4] = (disp_q[19:16] == 4'd0);
      blank[3] = blank[4] && (disp_q[15:12] == 4'd0);
      blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
      blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
      k        = 4'd10 - col;
      case (k[2:0])
         3'd0:    dig = disp_q[3:0];
         3'd1:    dig = disp_q[7:4];
         3'd2:    dig = disp_q[11:8];
         3'd3:    dig = disp_q[15:12];
         3'd4:    dig = disp_q[19:16];
         default: dig = 4'd0;
      endcase
      char_d = 7'h20;
      case (row)
         2'd0: begin
            if (col >= 4'd6 && col <= 4'd10) begin
               if (disp_oor_q)
                  char_d = 7'h2D;
               else if (blank[k[2:0]])
                  char_d = 7'h20;
               else
                  char_d = {3'b011, dig};
            end else begin
               char_d = str_at(ROW0, col);
            end
         end
         2'd1: begin
            if (no_sig)
               char_d = str_at(ROW_NS, col);
            else if (disp_oor_q)
               char_d = str_at(ROW_OR, col);
            else
               char_d = str_at(ROW_OK, col);
         end
         default: char_d = 7'h20;
      endcase
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst)
         char_q <= 7'h20;
      else
         char_q <= char_d;
   end

   assign char_code = char_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_distance_text_buffer.sv
// Directed bench for distance_text_buffer: screen reads, latency, boundaries,
// back-to-back samples and mid-conversion reset; second instance uses MAX_CM=65535.
module tb_distance_text_buffer;
   logic        pclk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] distance_cm = '0;
   logic        distance_valid = 1'b0;
   logic [6:0]  char_xy = '0;
   logic [6:0]  char_code, char_code2;
   logic        busy, busy2;

   int n_tests = 0;
   int n_fail  = 0;
   logic [6:0] q1[$];
   logic [6:0] q2[$];

   distance_text_buffer #(.MAX_CM(400)) dut (
      .pclk(pclk), .rst(rst), .distance_cm(distance_cm),
      .distance_valid(distance_valid), .char_xy(char_xy),
      .char_code(char_code), .busy(busy));

   distance_text_buffer #(.MAX_CM(65535)) dut_wide (
      .pclk(pclk), .rst(rst), .distance_cm(distance_cm),
      .distance_valid(distance_valid), .char_xy(char_xy),
      .char_code(char_code2), .busy(busy2));

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic string row_str(int r, int v, int mx);
      if (r == 0)
         return (v > mx) ? "DIST: ----- cm  " : $sformatf("DIST: %5d cm  ", v);
      if (r == 1)
         return (v > mx) ? "OUT OF RANGE    " : "STATUS: OK      ";
      return "                ";
   endfunction

   task automatic read_row(input int r, input int v);
      string s1, s2;
      logic [3:0] cc;
      s1 = row_str(r, v, 400);
      s2 = row_str(r, v, 65535);
      for (int c = 0; c < 17; c++) begin
         @(negedge pclk);
         if (q1.size() > 0) begin
            chk($sformatf("v%0d_r%0d_c%0d", v, r, c - 1), {25'd0, char_code}, {25'd0, q1.pop_front()});
            chk($sformatf("wide_v%0d_r%0d_c%0d", v, r, c - 1), {25'd0, char_code2}, {25'd0, q2.pop_front()});
         end
         if (c < 16) begin
            cc = 4'(c);
            char_xy = {cc[0], 2'(r), cc};
            q1.push_back(7'(s1[c]));
            q2.push_back(7'(s2[c]));
         end
      end
   endtask

   task automatic send(input int v);
      @(negedge pclk);
      distance_cm    = 16'(v);
      distance_valid = 1'b1;
      @(negedge pclk);
      distance_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || busy2) && n < 100) begin
         @(negedge pclk);
         n++;
      end
      chk("idle_bound", (n < 100) ? 1 : 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int vals[5] = '{9, 1000, 400, 401, 65535};
      int nb, hi, falls, saw2, saw5;
      logic pb;
      logic [6:0] last;

      #2 rst = 1'b1;
      repeat (3) @(negedge pclk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_busy_wide", {31'd0, busy2}, 0);
      chk("rst_char", {25'd0, char_code}, 32'h20);
      rst = 1'b0;
      for (int r = 0; r < 4; r++) read_row(r, 0);

      send(37);
      nb = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge pclk);
         if (!busy) break;
         nb++;
      end
      chk("busy_len_37", nb, 17);
      read_row(0, 37);
      read_row(1, 37);

      foreach (vals[i]) begin
         send(vals[i]);
         wait_idle();
         read_row(0, vals[i]);
         read_row(1, vals[i]);
      end

      char_xy = 7'h09;
      @(negedge pclk);
      hi = 0; falls = 0; saw2 = 0; saw5 = 0; pb = 1'b0; last = '0;
      fork
         begin
            send(120);
            repeat (3) @(negedge pclk);
            send(250);
            send(333);
         end
         begin
            @(negedge pclk);
            for (int i = 0; i < 60; i++) begin
               @(negedge pclk);
               if (busy) hi++;
               if (pb && !busy) falls++;
               pb = busy;
               if (char_code == 7'h32) saw2 = 1;
               if (char_code == 7'h35) saw5 = 1;
               last = char_code;
            end
         end
      join
      chk("b2b_busy_cycles", hi, 34);
      chk("b2b_busy_falls", falls, 1);
      chk("b2b_saw_120", saw2, 1);
      chk("b2b_never_250", saw5, 0);
      chk("b2b_final_tens", {25'd0, last}, 32'h33);
      wait_idle();
      read_row(0, 333);
      read_row(1, 333);

      send(999);
      repeat (7) @(negedge pclk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 0);
      chk("midrst_char", {25'd0, char_code}, 32'h20);
      @(negedge pclk);
      @(negedge pclk);
      rst = 1'b0;
      repeat (30) @(negedge pclk);
      chk("postrst_busy", {31'd0, busy}, 0);
      for (int r = 0; r < 4; r++) read_row(r, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
